// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, instruction bit map and state encoding for core_ctrl
package core_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int I_ACC      = 33;
  localparam int I_CEN_P    = 32;
  localparam int I_WEN_P    = 31;
  localparam int I_AP_LSB   = 20;
  localparam int I_CEN_X    = 19;
  localparam int I_WEN_X    = 18;
  localparam int I_AX_LSB   = 7;
  localparam int I_OFIFO_RD = 6;
  localparam int I_IFIFO_WR = 5;
  localparam int I_IFIFO_RD = 4;
  localparam int I_L0_RD    = 3;
  localparam int I_L0_WR    = 2;
  localparam int I_EXEC     = 1;
  localparam int I_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  localparam int               COL_DEF     = 8;
  localparam int               ROW_DEF     = 8;
  localparam int               LEN_NIJ_DEF = 36;
  localparam int               GAP_CYC_DEF = 10;
  localparam logic [ADDR_W-1:0] W_BASE_DEF = 11'h400;
  localparam logic [3:0]       KIJ_MAX     = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLD,
    S_KLD,
    S_GAP,
    S_XLD,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - sequences one kij pass: weight load, kernel load, activation stream, psum drain
module core_ctrl
  import core_pkg::*;
#(
  parameter int               COL     = COL_DEF,
  parameter int               ROW     = ROW_DEF,
  parameter int               LEN_NIJ = LEN_NIJ_DEF,
  parameter int               GAP_CYC = GAP_CYC_DEF,
  parameter logic [ADDR_W-1:0] W_BASE = W_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        kij,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int M1      = (COL + ROW > COL) ? COL + ROW : COL;
  localparam int M2      = (GAP_CYC > M1) ? GAP_CYC : M1;
  localparam int CNT_MAX = (LEN_NIJ + 1 > M2) ? LEN_NIJ + 1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PC_W    = $clog2(LEN_NIJ + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic [3:0]          kij_q, kij_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, done_q, err_q, err_d;
  logic                psum_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    kij_d   = kij_q;
    inst_d  = INST_IDLE;
    err_d   = 1'b0;

    // Psum writeback runs alongside both XLD and DRAIN and stops dead at LEN_NIJ rows
    psum_wr = ((state_q == S_XLD) || (state_q == S_DRAIN)) && ofifo_valid &&
              (pcnt_q < PC_W'(LEN_NIJ));
    if (psum_wr) begin
      inst_d[I_OFIFO_RD] = 1'b1;
      inst_d[I_CEN_P]    = 1'b0;
      inst_d[I_WEN_P]    = 1'b0;
      inst_d[I_AP_LSB +: ADDR_W] = ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ) + ADDR_W'(pcnt_q);
      pcnt_d = pcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          if (kij > KIJ_MAX) begin
            err_d = 1'b1;
          end else begin
            kij_d   = kij;
            cnt_d   = '0;
            pcnt_d  = '0;
            state_d = S_WLD;
          end
        end
      end
      S_WLD: begin
        inst_d[I_CEN_X] = 1'b0;
        inst_d[I_L0_WR] = 1'b1;
        inst_d[I_AX_LSB +: ADDR_W] = W_BASE + ADDR_W'(kij_q) * ADDR_W'(COL) + ADDR_W'(cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(COL - 1)) begin
          cnt_d   = '0;
          state_d = S_KLD;
        end
      end
      S_KLD: begin
        inst_d[I_L0_RD] = 1'b1;
        inst_d[I_LOAD]  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(COL + ROW - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_XLD;
        end
      end
      S_XLD: begin
        // L0 read/execute trail the L0 write by one cycle, hence LEN_NIJ+1 steps
        if (cnt_q < CNT_W'(LEN_NIJ)) begin
          inst_d[I_CEN_X] = 1'b0;
          inst_d[I_L0_WR] = 1'b1;
          inst_d[I_AX_LSB +: ADDR_W] = ADDR_W'(cnt_q);
        end
        if (cnt_q != '0) begin
          inst_d[I_L0_RD] = 1'b1;
          inst_d[I_EXEC]  = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LEN_NIJ)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pcnt_d == PC_W'(LEN_NIJ)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      kij_q   <= '0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      busy_q  <= (state_q != S_IDLE);
      done_q  <= (state_q == S_DONE);
      err_q   <= err_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
